// File: rtl/fir_mac_sched.sv
// Sequencing controller for the decimating FIR datapath: zeroes the tap buffer,
// then loops LOAD -> MAC -> DRAIN -> WRITE, issuing only enables and addresses.
module fir_mac_sched #(
  parameter int NUM_TAPS    = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int DECIM       = 8,
  parameter int MAC_LATENCY = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_empty,
  output logic                  in_rd_en,
  input  logic                  out_full,
  output logic                  out_wr_en,
  output logic                  buf_wr_en,
  output logic                  buf_wr_zero,
  output logic [ADDR_WIDTH-1:0] buf_wr_addr,
  output logic [ADDR_WIDTH-1:0] buf_rd_addr,
  output logic [ADDR_WIDTH-1:0] coeff_addr,
  output logic                  mac_en,
  output logic                  mac_clear,
  output logic                  busy,
  output logic [15:0]           out_count
);

  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int LW = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;

  localparam logic [ADDR_WIDTH-1:0] K_LAST    = ADDR_WIDTH'(NUM_TAPS - 1);
  localparam logic [ADDR_WIDTH:0]   TAPS_X    = (ADDR_WIDTH + 1)'(NUM_TAPS);
  localparam logic [DW-1:0]         DCNT_LAST = DW'(DECIM - 1);
  localparam logic [LW-1:0]         LCNT_LAST = LW'((MAC_LATENCY > 0) ? (MAC_LATENCY - 1) : 0);

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_MAC   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_WRITE = 3'd4
  } state_t;

  state_t                  state_r;
  logic [ADDR_WIDTH-1:0]   head_r;
  logic [DW-1:0]           dcnt_r;
  logic [ADDR_WIDTH-1:0]   k_r;
  logic [LW-1:0]           lcnt_r;
  logic [15:0]             out_count_r;

  // Buffer slot holding the sample k steps older than the newest: (head-1-k) mod NUM_TAPS.
  function automatic logic [ADDR_WIDTH-1:0] tap_rd_addr(
    input logic [ADDR_WIDTH-1:0] head,
    input logic [ADDR_WIDTH-1:0] k
  );
    logic [ADDR_WIDTH:0] sum;
    sum = {1'b0, head} + TAPS_X - {1'b0, k} - {{ADDR_WIDTH{1'b0}}, 1'b1};
    if (sum >= TAPS_X) begin
      sum = sum - TAPS_X;
    end else begin
      sum = sum;
    end
    return sum[ADDR_WIDTH-1:0];
  endfunction

  // Next circular write slot after head.
  function automatic logic [ADDR_WIDTH-1:0] head_inc(input logic [ADDR_WIDTH-1:0] head);
    logic [ADDR_WIDTH-1:0] nxt;
    if (head == K_LAST) begin
      nxt = '0;
    end else begin
      nxt = head + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    end
    return nxt;
  endfunction

  // Frame sequencer: state and all counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_INIT;
      head_r      <= '0;
      dcnt_r      <= '0;
      k_r         <= '0;
      lcnt_r      <= '0;
      out_count_r <= 16'd0;
    end else begin
      case (state_r)
        ST_INIT: begin
          if (k_r == K_LAST) begin
            k_r     <= '0;
            state_r <= ST_LOAD;
          end else begin
            k_r <= k_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
          end
        end
        ST_LOAD: begin
          if (!in_empty) begin
            head_r <= head_inc(head_r);
            if (dcnt_r == DCNT_LAST) begin
              dcnt_r  <= '0;
              k_r     <= '0;
              state_r <= ST_MAC;
            end else begin
              dcnt_r <= dcnt_r + {{(DW-1){1'b0}}, 1'b1};
            end
          end else begin
            state_r <= ST_LOAD;
          end
        end
        ST_MAC: begin
          if (k_r == K_LAST) begin
            k_r    <= '0;
            lcnt_r <= '0;
            if (MAC_LATENCY == 0) begin
              state_r <= ST_WRITE;
            end else begin
              state_r <= ST_DRAIN;
            end
          end else begin
            k_r <= k_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
          end
        end
        ST_DRAIN: begin
          if (lcnt_r == LCNT_LAST) begin
            lcnt_r  <= '0;
            state_r <= ST_WRITE;
          end else begin
            lcnt_r <= lcnt_r + {{(LW-1){1'b0}}, 1'b1};
          end
        end
        ST_WRITE: begin
          if (!out_full) begin
            out_count_r <= out_count_r + 16'd1;
            state_r     <= ST_LOAD;
          end else begin
            state_r <= ST_WRITE;
          end
        end
        default: begin
          state_r <= ST_INIT;
          k_r     <= '0;
        end
      endcase
    end
  end

  // Output decode; everything is forced quiet while reset is held.
  always_comb begin
    in_rd_en    = 1'b0;
    out_wr_en   = 1'b0;
    buf_wr_en   = 1'b0;
    buf_wr_zero = 1'b0;
    buf_wr_addr = '0;
    buf_rd_addr = '0;
    coeff_addr  = '0;
    mac_en      = 1'b0;
    mac_clear   = 1'b0;
    busy        = 1'b0;
    if (!reset) begin
      busy = 1'b0;
    end else begin
      case (state_r)
        ST_INIT: begin
          buf_wr_en   = 1'b1;
          buf_wr_zero = 1'b1;
          buf_wr_addr = k_r;
          busy        = 1'b1;
        end
        ST_LOAD: begin
          in_rd_en    = ~in_empty;
          buf_wr_en   = ~in_empty;
          buf_wr_addr = head_r;
        end
        ST_MAC: begin
          mac_en      = 1'b1;
          mac_clear   = (k_r == '0);
          coeff_addr  = k_r;
          buf_rd_addr = tap_rd_addr(head_r, k_r);
          busy        = 1'b1;
        end
        ST_DRAIN: begin
          busy = 1'b1;
        end
        ST_WRITE: begin
          out_wr_en = ~out_full;
          busy      = 1'b1;
        end
        default: begin
          busy = 1'b1;
        end
      endcase
    end
  end

  assign out_count = out_count_r;

endmodule

// Protocol invariants of fir_mac_sched, kept apart from the datapath-facing logic.
module fir_mac_sched_chk (
  input logic clock,
  input logic reset,
  input logic in_empty,
  input logic in_rd_en,
  input logic out_full,
  input logic out_wr_en,
  input logic buf_wr_en,
  input logic buf_wr_zero,
  input logic mac_en,
  input logic mac_clear,
  input logic busy
);

  a_no_wr_during_mac: assert property (@(posedge clock) disable iff (!reset)
    !(buf_wr_en && mac_en));

  a_no_pop_when_empty: assert property (@(posedge clock) disable iff (!reset)
    in_rd_en |-> !in_empty);

  a_no_push_when_full: assert property (@(posedge clock) disable iff (!reset)
    out_wr_en |-> !out_full);

  a_clear_needs_mac: assert property (@(posedge clock) disable iff (!reset)
    mac_clear |-> mac_en);

  a_zero_only_with_wr: assert property (@(posedge clock) disable iff (!reset)
    buf_wr_zero |-> buf_wr_en);

  a_pop_only_idle: assert property (@(posedge clock) disable iff (!reset)
    in_rd_en |-> !busy);

endmodule

// File: tb/tb_fir_mac_sched.sv
// Directed bench for fir_mac_sched: init sweep, frame schedule, wrap, stalls, reset abort.
module tb_fir_mac_sched;

  logic       clock;
  logic       reset;
  logic       in_empty;
  logic       in_rd_en;
  logic       out_full;
  logic       out_wr_en;
  logic       buf_wr_en;
  logic       buf_wr_zero;
  logic [4:0] buf_wr_addr;
  logic [4:0] buf_rd_addr;
  logic [4:0] coeff_addr;
  logic       mac_en;
  logic       mac_clear;
  logic       busy;
  logic [15:0] out_count;

  int checks;
  int failures;
  int exp_head;
  int exp_count;

  fir_mac_sched #(
    .NUM_TAPS(32), .ADDR_WIDTH(5), .DECIM(8), .MAC_LATENCY(2)
  ) dut (
    .clock(clock), .reset(reset), .in_empty(in_empty), .in_rd_en(in_rd_en),
    .out_full(out_full), .out_wr_en(out_wr_en), .buf_wr_en(buf_wr_en),
    .buf_wr_zero(buf_wr_zero), .buf_wr_addr(buf_wr_addr), .buf_rd_addr(buf_rd_addr),
    .coeff_addr(coeff_addr), .mac_en(mac_en), .mac_clear(mac_clear), .busy(busy),
    .out_count(out_count)
  );

  fir_mac_sched_chk u_chk (
    .clock(clock), .reset(reset), .in_empty(in_empty), .in_rd_en(in_rd_en),
    .out_full(out_full), .out_wr_en(out_wr_en), .buf_wr_en(buf_wr_en),
    .buf_wr_zero(buf_wr_zero), .mac_en(mac_en), .mac_clear(mac_clear), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive inputs on the falling edge, let decode settle, then observe.
  task automatic cycle(input logic emp, input logic full);
    @(negedge clock);
    in_empty = emp;
    out_full = full;
    #1;
  endtask

  task automatic check_init_sweep();
    for (int i = 0; i < 32; i++) begin
      if (i > 0) cycle(1'b1, 1'b0);
      checks++;
      if (buf_wr_en !== 1'b1 || buf_wr_zero !== 1'b1 || busy !== 1'b1 || in_rd_en !== 1'b0) begin
        failures++;
        $display("FAIL init_ctrl i=%0d got wr=%b zero=%b busy=%b rd=%b exp 1 1 1 0",
                 i, buf_wr_en, buf_wr_zero, busy, in_rd_en);
      end
      checks++;
      if (buf_wr_addr !== 5'(i)) begin
        failures++;
        $display("FAIL init_addr i=%0d got=%0d exp=%0d", i, buf_wr_addr, i);
      end
    end
    cycle(1'b1, 1'b0);
    checks++;
    if (busy !== 1'b0 || in_rd_en !== 1'b0 || buf_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL init_done got busy=%b rd=%b wr=%b exp 0 0 0", busy, in_rd_en, buf_wr_en);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    in_empty = 1'b1;
    out_full = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0);
      checks++;
      if ({in_rd_en, out_wr_en, buf_wr_en, buf_wr_zero, mac_en, mac_clear, busy} !== 7'd0 ||
          buf_wr_addr !== 5'd0 || buf_rd_addr !== 5'd0 || coeff_addr !== 5'd0 ||
          out_count !== 16'd0) begin
        failures++;
        $display("FAIL reset_hold got en=%b%b%b%b%b%b%b wa=%0d ra=%0d ca=%0d cnt=%0d exp all 0",
                 in_rd_en, out_wr_en, buf_wr_en, buf_wr_zero, mac_en, mac_clear, busy,
                 buf_wr_addr, buf_rd_addr, coeff_addr, out_count);
      end
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_init_sweep();
    exp_head = 0;
    exp_count = 0;
  endtask

  // One frame: 8 accepts (optionally with in_empty toggling), 32 MAC cycles,
  // drain, then WRITE with out_full held for full_cycles.
  task automatic run_frame(input bit toggle, input int full_cycles);
    int  accepts;
    int  guard;
    int  n;
    int  got_n;
    bit  emp;
    bit  full;
    accepts = 0;
    guard = 0;
    while (accepts < 8 && guard < 40) begin
      emp = toggle && (guard % 2 == 1);
      cycle(emp, 1'b0);
      checks++;
      if (in_rd_en !== !emp || buf_wr_en !== !emp || busy !== 1'b0 || mac_en !== 1'b0) begin
        failures++;
        $display("FAIL load_ctrl emp=%b got rd=%b wr=%b busy=%b mac=%b exp rd=%b wr=%b busy=0 mac=0",
                 emp, in_rd_en, buf_wr_en, busy, mac_en, !emp, !emp);
      end
      if (!emp) begin
        checks++;
        if (buf_wr_addr !== 5'(exp_head) || buf_wr_zero !== 1'b0) begin
          failures++;
          $display("FAIL load_addr got=%0d zero=%b exp=%0d zero=0", buf_wr_addr, buf_wr_zero, exp_head);
        end
        accepts++;
        exp_head = (exp_head + 1) % 32;
      end
      guard++;
    end
    checks++;
    if (accepts != 8) begin
      failures++;
      $display("FAIL load_timeout got accepts=%0d exp=8", accepts);
    end
    n = 0;
    got_n = -1;
    while (got_n < 0 && n < 80) begin
      n++;
      full = (n >= 35) && (n < 35 + full_cycles);
      cycle(1'b1, full);
      if (n <= 32) begin
        checks++;
        if (mac_en !== 1'b1 || coeff_addr !== 5'(n - 1) ||
            buf_rd_addr !== 5'((exp_head - n + 32) % 32) || mac_clear !== (n == 1) ||
            buf_wr_en !== 1'b0 || in_rd_en !== 1'b0 || busy !== 1'b1) begin
          failures++;
          $display("FAIL mac_step n=%0d got en=%b ca=%0d ra=%0d clr=%b wr=%b rd=%b exp en=1 ca=%0d ra=%0d clr=%b wr=0 rd=0",
                   n, mac_en, coeff_addr, buf_rd_addr, mac_clear, buf_wr_en, in_rd_en,
                   n - 1, (exp_head - n + 32) % 32, (n == 1));
        end
      end else if (out_wr_en !== 1'b1) begin
        checks++;
        if (mac_en !== 1'b0 || busy !== 1'b1 || in_rd_en !== 1'b0 || out_count !== 16'(exp_count)) begin
          failures++;
          $display("FAIL post_mac n=%0d got mac=%b busy=%b rd=%b cnt=%0d exp 0 1 0 %0d",
                   n, mac_en, busy, in_rd_en, out_count, exp_count);
        end
      end
      if (out_wr_en === 1'b1) got_n = n;
    end
    checks++;
    if (got_n != 35 + full_cycles) begin
      failures++;
      $display("FAIL write_latency got=%0d exp=%0d", got_n, 35 + full_cycles);
    end
    exp_count++;
    cycle(1'b1, 1'b0);
    checks++;
    if (out_wr_en !== 1'b0 || busy !== 1'b0 || out_count !== 16'(exp_count)) begin
      failures++;
      $display("FAIL after_write got wr=%b busy=%b cnt=%0d exp 0 0 %0d",
               out_wr_en, busy, out_count, exp_count);
    end
  endtask

  task automatic test_first_frame();
    run_frame(1'b0, 0);
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 3; f++) run_frame(1'b0, 0);
    checks++;
    if (out_count !== 16'd4 || exp_head != 0) begin
      failures++;
      $display("FAIL four_frames got cnt=%0d head=%0d exp cnt=4 head=0", out_count, exp_head);
    end
    run_frame(1'b0, 0);
  endtask

  task automatic test_load_stall();
    run_frame(1'b1, 0);
  endtask

  task automatic test_out_full();
    run_frame(1'b0, 10);
  endtask

  task automatic test_reset_mid_mac();
    int stray;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b0);
      checks++;
      if (in_rd_en !== 1'b1) begin
        failures++;
        $display("FAIL abort_load i=%0d got=%b exp=1", i, in_rd_en);
      end
    end
    for (int n = 1; n <= 13; n++) cycle(1'b1, 1'b0);
    checks++;
    if (coeff_addr !== 5'd12 || mac_en !== 1'b1) begin
      failures++;
      $display("FAIL abort_point got ca=%0d mac=%b exp ca=12 mac=1", coeff_addr, mac_en);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (mac_en !== 1'b0 || mac_clear !== 1'b0 || busy !== 1'b0 || coeff_addr !== 5'd0 ||
        buf_rd_addr !== 5'd0 || out_count !== 16'd0 || out_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL abort_reset got mac=%b clr=%b busy=%b ca=%0d ra=%0d cnt=%0d wr=%b exp all 0",
               mac_en, mac_clear, busy, coeff_addr, buf_rd_addr, out_count, out_wr_en);
    end
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_init_sweep();
    exp_head = 0;
    exp_count = 0;
    stray = 0;
    for (int i = 0; i < 50; i++) begin
      cycle(1'b1, 1'b0);
      if (out_wr_en !== 1'b0 || out_count !== 16'd0) stray++;
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("FAIL abort_no_write got stray=%0d exp=0", stray);
    end
    run_frame(1'b0, 0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    exp_head = 0;
    exp_count = 0;
    test_reset();
    test_first_frame();
    test_back_to_back();
    test_load_stall();
    test_out_full();
    test_reset_mid_mac();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
